rcc_rst_seq: RTL and testbench



---
 rtl/rcc_pkg.sv | 23 ++
 rtl/rcc_rst_chan.sv | 101 ++++++++++
 rtl/rcc_rst_seq.sv | 62 ++++++
 tb/tb_rcc_rst_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcc_pkg.sv
// Shared encodings and helpers for the RCC multi-domain reset sequencer.
package rcc_pkg;

  localparam logic [1:0] RST_HOLD    = 2'd0;
  localparam logic [1:0] WAIT_PARENT = 2'd1;
  localparam logic [1:0] CLK_WAIT    = 2'd2;
  localparam logic [1:0] RUN         = 2'd3;

  // Widest packed per-domain vector the field helper accepts.
  localparam int unsigned MAX_VEC_W = 1024;

  // Field idx of width w (w <= 32) from a packed per-domain duration vector.
  function automatic int unsigned field_get(input logic [MAX_VEC_W-1:0] vec,
                                            input int unsigned           idx,
                                            input int unsigned           w);
    logic [MAX_VEC_W-1:0] shifted;
    logic [63:0]          mask;
    shifted = vec >> (idx * w);
    mask    = (64'd1 << w) - 64'd1;
    return shifted[31:0] & mask[31:0];
  endfunction

endpackage

// File: rtl/rcc_rst_chan.sv
// One reset domain: reset hold counter, optional parent gating and clock-on delay.
// Outputs are registered copies of the next-state decode.
module rcc_rst_chan
  import rcc_pkg::*;
#(
  parameter int unsigned CntW   = 8,
  parameter int unsigned RstDur = 10,
  parameter int unsigned ClkDly = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic parent_ok,
  output logic dom_rst,
  output logic clk_en,
  output logic ready,
  output logic ready_nxt
);

  // A zero hold duration still holds reset for one cycle.
  localparam logic [CntW-1:0] HoldLast = CntW'((RstDur == 0) ? 32'd0 : RstDur - 1);
  localparam logic [CntW-1:0] DlyLast  = CntW'((ClkDly == 0) ? 32'd0 : ClkDly - 1);
  localparam logic            DlyZero  = (ClkDly == 0);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            rst_q, rst_d;
  logic            run_q, run_d;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (req) begin
      state_d = RST_HOLD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RST_HOLD: begin
          if (cnt_q == HoldLast) begin
            state_d = parent_ok ? CLK_WAIT : WAIT_PARENT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        WAIT_PARENT: begin
          if (parent_ok) begin
            state_d = CLK_WAIT;
            cnt_d   = '0;
          end
        end
        CLK_WAIT: begin
          if (!parent_ok) begin
            state_d = RST_HOLD;
            cnt_d   = '0;
          end else if (DlyZero || cnt_q == DlyLast) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RUN: begin
          if (!parent_ok) begin
            state_d = RST_HOLD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign rst_d = (state_d == RST_HOLD) || (state_d == WAIT_PARENT);
  assign run_d = (state_d == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      run_q   <= run_d;
    end
  end

  assign dom_rst   = rst_q;
  assign clk_en    = run_q;
  assign ready     = run_q;
  assign ready_nxt = run_d;

endmodule

// File: rtl/rcc_rst_seq.sv
// Multi-domain reset / clock-enable sequencer: NUM_DOM independent channels, each with
// its own hold time and clock-on delay, optionally chained to the previous domain.
module rcc_rst_seq
  import rcc_pkg::*;
#(
  parameter int unsigned                NUM_DOM    = 6,
  parameter int unsigned                CNT_W      = 8,
  parameter logic [NUM_DOM*CNT_W-1:0]   RST_DUR    = {NUM_DOM{CNT_W'(10)}},
  parameter logic [NUM_DOM*CNT_W-1:0]   CLK_DLY    = {NUM_DOM{CNT_W'(8)}},
  parameter logic [NUM_DOM-1:0]         CHAIN_MASK = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DOM-1:0] rst_req,
  output logic [NUM_DOM-1:0] dom_rst,
  output logic [NUM_DOM-1:0] dom_clk_en,
  output logic [NUM_DOM-1:0] dom_ready,
  output logic               busy
);

  logic [NUM_DOM-1:0] parent_ok;
  logic [NUM_DOM-1:0] ready_nxt;
  logic               busy_q;

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    localparam int unsigned Dur = field_get(MAX_VEC_W'(RST_DUR), unsigned'(i), CNT_W);
    localparam int unsigned Dly = field_get(MAX_VEC_W'(CLK_DLY), unsigned'(i), CNT_W);

    if (i == 0 || !CHAIN_MASK[i]) begin : g_free
      assign parent_ok[i] = 1'b1;
    end else begin : g_chain
      assign parent_ok[i] = dom_ready[i-1];
    end

    rcc_rst_chan #(
      .CntW   (CNT_W),
      .RstDur (Dur),
      .ClkDly (Dly)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .req       (rst_req[i]),
      .parent_ok (parent_ok[i]),
      .dom_rst   (dom_rst[i]),
      .clk_en    (dom_clk_en[i]),
      .ready     (dom_ready[i]),
      .ready_nxt (ready_nxt[i])
    );
  end

  // Built from next-state readiness so busy moves on the same edge as dom_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b1;
    end else begin
      busy_q <= ~&ready_nxt;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_rcc_rst_seq.sv
// Bench for rcc_rst_seq: a default instance (A) and a chained/boundary instance (B),
// checked cycle by cycle against a reference model plus hand-timed sequences.
module tb_rcc_rst_seq;

  localparam logic [47:0] B_DUR   = {8'd10, 8'd10, 8'd0, 8'd10, 8'd10, 8'd20};
  localparam logic [47:0] B_DLY   = {8'd8, 8'd8, 8'd0, 8'd8, 8'd8, 8'd8};
  localparam logic [5:0]  B_CHAIN = 6'b000110;

  localparam int S_HOLD = 0;
  localparam int S_WAIT = 1;
  localparam int S_CLKW = 2;
  localparam int S_RUN  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] req_a = '0;
  logic [5:0] req_b = '0;
  logic [5:0] rst_a, en_a, rdy_a, rst_b, en_b, rdy_b;
  logic       busy_a, busy_b;

  always #5 clk = ~clk;

  rcc_rst_seq u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .rst_req    (req_a),
    .dom_rst    (rst_a),
    .dom_clk_en (en_a),
    .dom_ready  (rdy_a),
    .busy       (busy_a)
  );

  rcc_rst_seq #(
    .RST_DUR    (B_DUR),
    .CLK_DLY    (B_DLY),
    .CHAIN_MASK (B_CHAIN)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .rst_req    (req_b),
    .dom_rst    (rst_b),
    .dom_clk_en (en_b),
    .dom_ready  (rdy_b),
    .busy       (busy_b)
  );

  typedef struct packed {
    logic [5:0] rst_a, en_a, rdy_a, rst_b, en_b, rdy_b;
    logic       busy_a, busy_b;
  } exp_t;

  typedef struct {
    logic [5:0] req;
    int         n;
    logic [5:0] exp_rst;
    logic [5:0] exp_en;
  } vec_t;

  exp_t       sb[$];
  int         m_state[2][6];
  int         m_cnt[2][6];
  int         m_dur[2][6];
  int         m_dly[2][6];
  bit         m_chain[2][6];
  logic [5:0] m_rst[2];
  logic [5:0] m_rdy[2];
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) begin
        m_state[k][i] = S_HOLD;
        m_cnt[k][i]   = 0;
      end
      m_rst[k] = 6'h3F;
      m_rdy[k] = 6'h00;
    end
  endfunction

  task automatic model_step(input logic [5:0] qa, input logic [5:0] qb);
    for (int k = 0; k < 2; k++) begin
      logic [5:0] q;
      logic [5:0] prev;
      q    = (k == 0) ? qa : qb;
      prev = m_rdy[k];
      for (int i = 0; i < 6; i++) begin
        bit pok;
        int last;
        pok  = (i == 0) || !m_chain[k][i] || prev[i-1];
        last = (m_dur[k][i] == 0) ? 0 : m_dur[k][i] - 1;
        if (q[i]) begin
          m_state[k][i] = S_HOLD;
          m_cnt[k][i]   = 0;
        end else begin
          case (m_state[k][i])
            S_HOLD: begin
              if (m_cnt[k][i] == last) begin
                m_state[k][i] = pok ? S_CLKW : S_WAIT;
                m_cnt[k][i]   = 0;
              end else m_cnt[k][i]++;
            end
            S_WAIT: begin
              if (pok) begin
                m_state[k][i] = S_CLKW;
                m_cnt[k][i]   = 0;
              end
            end
            S_CLKW: begin
              if (!pok) begin
                m_state[k][i] = S_HOLD;
                m_cnt[k][i]   = 0;
              end else if (m_dly[k][i] == 0 || m_cnt[k][i] == m_dly[k][i] - 1) begin
                m_state[k][i] = S_RUN;
                m_cnt[k][i]   = 0;
              end else m_cnt[k][i]++;
            end
            default: begin
              if (!pok) begin
                m_state[k][i] = S_HOLD;
                m_cnt[k][i]   = 0;
              end
            end
          endcase
        end
        m_rst[k][i] = (m_state[k][i] == S_HOLD) || (m_state[k][i] == S_WAIT);
        m_rdy[k][i] = (m_state[k][i] == S_RUN);
      end
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.rst_a  = m_rst[0];
    e.en_a   = m_rdy[0];
    e.rdy_a  = m_rdy[0];
    e.rst_b  = m_rst[1];
    e.en_b   = m_rdy[1];
    e.rdy_b  = m_rdy[1];
    e.busy_a = ~&m_rdy[0];
    e.busy_b = ~&m_rdy[1];
    return e;
  endfunction

  // Called at a negedge: compare outputs of the last posedge, drive, predict, advance.
  task automatic cycle(input logic r, input logic [5:0] qa, input logic [5:0] qb);
    exp_t e;
    exp_t got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {rst_a, en_a, rdy_a, rst_b, en_b, rdy_b, busy_a, busy_b};
      check("scoreboard", 64'(got), 64'(e));
    end
    rst   = r;
    req_a = qa;
    req_b = qb;
    if (r) model_reset();
    else model_step(qa, qb);
    sb.push_back(model_exp());
    @(negedge clk);
  endtask

  // Release reset and time every start-up milestone on both instances.
  task automatic boot_measure(input string tag);
    int t_rst_a, t_en_a, t_rst_b0, t_rst_b1, t_rdy_b0, t_rdy_b1, t_rdy_b2, t_rst_b3, t_en_b3;
    t_rst_a = -1; t_en_a = -1; t_rst_b0 = -1; t_rst_b1 = -1; t_rdy_b0 = -1;
    t_rdy_b1 = -1; t_rdy_b2 = -1; t_rst_b3 = -1; t_en_b3 = -1;
    for (int n = 1; n <= 60; n++) begin
      cycle(1'b0, '0, '0);
      if (t_rst_a  < 0 && rst_a == 6'h00) t_rst_a  = n;
      if (t_en_a   < 0 && en_a == 6'h3F)  t_en_a   = n;
      if (t_rst_b0 < 0 && !rst_b[0])      t_rst_b0 = n;
      if (t_rst_b1 < 0 && !rst_b[1])      t_rst_b1 = n;
      if (t_rdy_b0 < 0 && rdy_b[0])       t_rdy_b0 = n;
      if (t_rdy_b1 < 0 && rdy_b[1])       t_rdy_b1 = n;
      if (t_rdy_b2 < 0 && rdy_b[2])       t_rdy_b2 = n;
      if (t_rst_b3 < 0 && !rst_b[3])      t_rst_b3 = n;
      if (t_en_b3  < 0 && en_b[3])        t_en_b3  = n;
    end
    check({tag, "_a_rst_release"}, 64'(t_rst_a), 64'(10));
    check({tag, "_a_clk_en_on"},   64'(t_en_a),   64'(18));
    check({tag, "_b0_rst_release"}, 64'(t_rst_b0), 64'(20));
    check({tag, "_b0_ready"},      64'(t_rdy_b0), 64'(28));
    check({tag, "_b1_rst_release"}, 64'(t_rst_b1), 64'(29));
    check({tag, "_b1_ready"},      64'(t_rdy_b1), 64'(37));
    check({tag, "_b2_ready"},      64'(t_rdy_b2), 64'(46));
    check({tag, "_b3_rst_release"}, 64'(t_rst_b3), 64'(1));
    check({tag, "_b3_clk_en_on"},  64'(t_en_b3),  64'(2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   t_lo, t_hi, hi_cnt, others_bad, r13, r14;
    int   t_fall[3];
    int   t_rise[3];

    for (int i = 0; i < 6; i++) begin
      m_dur[0][i] = 10; m_dly[0][i] = 8; m_chain[0][i] = 1'b0;
      m_dur[1][i] = 10; m_dly[1][i] = 8; m_chain[1][i] = 1'b0;
    end
    m_dur[1][0]   = 20;
    m_dur[1][3]   = 0;
    m_dly[1][3]   = 0;
    m_chain[1][1] = 1'b1;
    m_chain[1][2] = 1'b1;
    model_reset();

    tbl[0] = '{req: 6'b000011, n: 1,  exp_rst: 6'b000011, exp_en: 6'b111100};
    tbl[1] = '{req: 6'b000000, n: 5,  exp_rst: 6'b000011, exp_en: 6'b111100};
    tbl[2] = '{req: 6'b110000, n: 2,  exp_rst: 6'b110011, exp_en: 6'b001100};
    tbl[3] = '{req: 6'b000000, n: 3,  exp_rst: 6'b110000, exp_en: 6'b001100};
    tbl[4] = '{req: 6'b000000, n: 10, exp_rst: 6'b000000, exp_en: 6'b001111};
    tbl[5] = '{req: 6'b000000, n: 10, exp_rst: 6'b000000, exp_en: 6'b111111};

    @(negedge clk);
    repeat (3) cycle(1'b1, '0, '0);
    check("por_dom_rst_a", 64'(rst_a), 64'(6'h3F));
    check("por_busy_a", 64'(busy_a), 64'(1));
    boot_measure("por");

    // Single one-cycle request on A domain 2.
    t_lo = -1; t_hi = -1; hi_cnt = 0; others_bad = 0;
    for (int n = 0; n <= 30; n++) begin
      cycle(1'b0, (n == 0) ? 6'b000100 : 6'b000000, '0);
      if (rst_a[2]) hi_cnt++;
      if (t_lo < 0 && !rst_a[2]) t_lo = n;
      if (t_hi < 0 && en_a[2]) t_hi = n;
      if ((en_a & 6'b111011) != 6'b111011) others_bad++;
    end
    check("single_rst_cycles", 64'(hi_cnt), 64'(10));
    check("single_rst_release", 64'(t_lo), 64'(10));
    check("single_clk_en_back", 64'(t_hi), 64'(18));
    check("single_others_untouched", 64'(others_bad), 64'(0));

    // Re-request on A domain 5 while it sits in CLK_WAIT.
    t_hi = -1; r13 = -1; r14 = -1;
    for (int n = 0; n <= 45; n++) begin
      cycle(1'b0, (n == 0 || n == 14) ? 6'b100000 : 6'b000000, '0);
      if (n == 13) r13 = int'(rst_a[5]);
      if (n == 14) r14 = int'(rst_a[5]);
      if (t_hi < 0 && en_a[5]) t_hi = n;
    end
    check("rereq_clk_wait_rst_low", 64'(r13), 64'(0));
    check("rereq_rst_reasserted", 64'(r14), 64'(1));
    check("rereq_clk_en_on", 64'(t_hi), 64'(32));

    // Table-driven request patterns on A.
    foreach (tbl[v]) begin
      for (int c = 0; c < tbl[v].n; c++) cycle(1'b0, (c == 0) ? tbl[v].req : 6'b000000, '0);
      check($sformatf("table%0d_dom_rst", v), 64'(rst_a), 64'(tbl[v].exp_rst));
      check($sformatf("table%0d_clk_en", v), 64'(en_a), 64'(tbl[v].exp_en));
    end

    // Cascade down the B chain from a pulse on domain 0.
    for (int k = 0; k < 3; k++) begin t_fall[k] = -1; t_rise[k] = -1; end
    t_hi = -1;
    for (int n = 0; n <= 60; n++) begin
      cycle(1'b0, '0, (n == 0) ? 6'b000001 : 6'b000000);
      for (int k = 0; k < 3; k++) begin
        if (t_fall[k] < 0 && !en_b[k]) t_fall[k] = n;
        else if (t_fall[k] >= 0 && t_rise[k] < 0 && rdy_b[k]) t_rise[k] = n;
      end
      if (t_hi < 0 && rst_b[1]) t_hi = n;
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("cascade_fall%0d", k), 64'(t_fall[k]), 64'(k));
    end
    check("cascade_rst1_same_cycle", 64'(t_hi), 64'(1));
    check("cascade_rise0", 64'(t_rise[0]), 64'(28));
    check("cascade_rise1", 64'(t_rise[1]), 64'(37));
    check("cascade_rise2", 64'(t_rise[2]), 64'(46));

    // Held request on zero-duration domain B3, then release.
    hi_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(1'b0, '0, 6'b001000);
      if (rst_b[3] && !en_b[3]) hi_cnt++;
    end
    check("held_req_b3", 64'(hi_cnt), 64'(6));
    t_lo = -1; t_hi = -1;
    for (int n = 1; n <= 5; n++) begin
      cycle(1'b0, '0, '0);
      if (t_lo < 0 && !rst_b[3]) t_lo = n;
      if (t_hi < 0 && en_b[3]) t_hi = n;
    end
    check("zero_dur_rst_release", 64'(t_lo), 64'(1));
    check("zero_dly_clk_en_on", 64'(t_hi), 64'(2));

    // Asynchronous reset mid-operation, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_dom_rst_a", 64'(rst_a), 64'(6'h3F));
    check("async_clk_en_a", 64'(en_a), 64'(6'h00));
    check("async_busy_a", 64'(busy_a), 64'(1));
    check("async_dom_rst_b", 64'(rst_b), 64'(6'h3F));
    check("async_ready_b", 64'(rdy_b), 64'(6'h00));
    sb.delete();
    model_reset();
    sb.push_back(model_exp());
    @(negedge clk);
    repeat (2) cycle(1'b1, '0, '0);
    boot_measure("async");
    cycle(1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
